// File: rtl/ssram_byte_lsu_if.sv
// Request/response handshake and byte-wide SRAM port of the ssram_byte_lsu sequencer.
// The slave modport is the sequencer; master is its requester plus the SRAM.
interface ssram_byte_lsu_if #(parameter int AW = 9);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic          sram_cen;
  logic          sram_gwen;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d;
  logic [7:0]    sram_q;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_q,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, sram_cen, sram_gwen, sram_a, sram_d
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_q,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, sram_cen, sram_gwen, sram_a, sram_d
  );
endinterface

// File: rtl/ssram_byte_lsu.sv
// Byte/half/word load-store sequencer in front of a byte-wide single-port SRAM.
// Splits each request into little-endian byte accesses, bounds-checks it and returns one response pulse.
module ssram_byte_lsu #(
  parameter int AW = 9
) (
  input logic             CLK,
  input logic             RSTN,
  ssram_byte_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    issue_q, issue_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    cap_q, cap_d;
  logic          pend_q, pend_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          cen_q, cen_d;
  logic          gwen_q, gwen_d;
  logic [AW-1:0] a_q, a_d;
  logic [7:0]    d_q, d_d;

  logic [31:0]   rmerge_s;
  logic [1:0]    nlast_s;
  logic [AW:0]   end_addr_s;
  logic          req_err_s;
  logic [1:0]    issue_nx_s;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      2'd3:    byte_sel = w[31:24];
      default: byte_sel = 8'd0;
    endcase
  endfunction

  function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'd0:    extend = sgn ? {{24{r[7]}}, r[7:0]}   : {24'd0, r[7:0]};
      2'd1:    extend = sgn ? {{16{r[15]}}, r[15:0]} : {16'd0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  // Next-state, request capture, load-byte capture and registered output values.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_d     = issue_q;
    last_d      = last_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    cen_d       = 1'b0;
    gwen_d      = 1'b1;
    a_d         = '0;
    d_d         = 8'd0;
    issue_nx_s  = issue_q + 2'd1;

    // A read on the bus this cycle returns its byte in the next cycle.
    pend_d   = cen_q & gwen_q;
    rmerge_s = pend_q ? byte_put(rbuf_q, cap_q, bus.sram_q) : rbuf_q;
    rbuf_d   = rmerge_s;
    cap_d    = pend_q ? (cap_q + 2'd1) : cap_q;

    case (bus.req_size)
      2'd0:    nlast_s = 2'd0;
      2'd1:    nlast_s = 2'd1;
      default: nlast_s = 2'd3;
    endcase
    end_addr_s = {1'b0, bus.req_addr} + {{(AW-1){1'b0}}, nlast_s};
    req_err_s  = (bus.req_size == 2'd3) || end_addr_s[AW];

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          last_d  = nlast_s;
          issue_d = 2'd0;
          cap_d   = 2'd0;
          rbuf_d  = 32'd0;
          if (req_err_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            cen_d   = 1'b1;
            gwen_d  = ~bus.req_we;
            a_d     = bus.req_addr;
            d_d     = bus.req_we ? bus.req_wdata[7:0] : 8'd0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (issue_q == last_q) begin
          if (we_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          issue_d = issue_nx_s;
          cen_d   = 1'b1;
          gwen_d  = ~we_q;
          a_d     = addr_q + {{(AW-2){1'b0}}, issue_nx_s};
          d_d     = we_q ? byte_sel(wdata_q, issue_nx_s) : 8'd0;
        end
      end
      S_DRAIN: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = extend(rmerge_s, size_q, sgn_q);
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence and idles the SRAM port at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      issue_q     <= 2'd0;
      last_q      <= 2'd0;
      cap_q       <= 2'd0;
      pend_q      <= 1'b0;
      rbuf_q      <= 32'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      cen_q       <= 1'b0;
      gwen_q      <= 1'b1;
      a_q         <= '0;
      d_q         <= 8'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_q     <= issue_d;
      last_q      <= last_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      rbuf_q      <= rbuf_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cen_q       <= cen_d;
      gwen_q      <= gwen_d;
      a_q         <= a_d;
      d_q         <= d_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.sram_cen  = cen_q;
  assign bus.sram_gwen = gwen_q;
  assign bus.sram_a    = a_q;
  assign bus.sram_d    = d_q;

endmodule
